// File: rtl/lfsr_arb.sv
// lfsr_arb: seeded LFSR random-word source shared by two requesters.
// Grants alternate round-robin, and the LFSR is stirred STEPS times between grants.
module lfsr_arb #(
    parameter int LEN   = 7,
    parameter int STEPS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_load,
    input  logic [LEN:0] seed,
    input  logic         req0,
    input  logic         req1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [LEN:0] rnd,
    output logic         ready,
    output logic         seeded
);

    localparam logic [3:0] STEPS_C = 4'(STEPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STIR  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [LEN:0] q;
    logic [3:0]   cnt;
    logic         prio;
    logic         grant;
    logic         pick1;

    // An all-zero register would lock the LFSR, so that case loads 1 instead.
    function automatic logic [LEN:0] seed_fix(input logic [LEN:0] s);
        logic [LEN:0] inv;
        inv = ~s;
        return (inv == '0) ? {{LEN{1'b0}}, 1'b1} : inv;
    endfunction

    function automatic logic [LEN:0] lfsr_step(input logic [LEN:0] v);
        return {v[LEN-1:0], v[LEN] ^ v[LEN-1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A seed load overrides everything, including a grant in the same cycle.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        pick1     = 1'b0;
        if (seed_load) begin
            state_nxt = STIR;
        end else begin
            case (state)
                STIR: begin
                    if (cnt <= 4'd1) begin
                        state_nxt = READY;
                    end
                end
                READY: begin
                    if (req0 || req1) begin
                        grant     = 1'b1;
                        pick1     = req1 & (~req0 | prio);
                        state_nxt = STIR;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            cnt    <= '0;
            prio   <= 1'b0;
            rnd    <= '0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            seeded <= 1'b0;
        end else begin
            gnt0 <= grant & ~pick1;
            gnt1 <= grant & pick1;
            if (seed_load) begin
                q      <= seed_fix(seed);
                cnt    <= STEPS_C;
                seeded <= 1'b1;
            end else if (state == STIR) begin
                q   <= lfsr_step(q);
                cnt <= cnt - 4'd1;
            end else if (grant) begin
                rnd  <= q;
                cnt  <= STEPS_C;
                prio <= ~pick1;
            end
        end
    end

    assign ready = (state == READY);

endmodule

// File: tb/tb_lfsr_arb.sv
// Bench for lfsr_arb: directed sequences plus protocol-following random traffic,
// all compared every cycle against a timestamp-based model of grants and words.
module tb_lfsr_arb;

    localparam int LEN   = 7;
    localparam int STEPS = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         seed_load = 1'b0;
    logic [LEN:0] seed = '0;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic         gnt0;
    logic         gnt1;
    logic [LEN:0] rnd;
    logic         ready;
    logic         seeded;

    int checks = 0;
    int errors = 0;

    lfsr_arb #(.LEN(LEN), .STEPS(STEPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .req0      (req0),
        .req1      (req1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rnd       (rnd),
        .ready     (ready),
        .seeded    (seeded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: the word offered after a load or grant is that value advanced
    // STEPS times, and it becomes available STEPS edges after that event.
    function automatic logic [7:0] shiftn(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) begin
            r = 8'(((r << 1) | ((r >> 7) ^ (r >> 6)) & 8'h01) & 8'hFF);
        end
        return r;
    endfunction

    int         ecount = 0;
    int         m_rdy_edge = 0;
    logic       m_seeded = 1'b0;
    logic       m_prio = 1'b0;
    logic       m_g0 = 1'b0;
    logic       m_g1 = 1'b0;
    logic [7:0] m_rnd = 8'h00;
    logic [7:0] m_word = 8'h00;

    always @(posedge clk) ecount <= ecount + 1;

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0] b;
        logic       who;
        if (!rst_n) begin
            m_seeded <= 1'b0;
            m_prio   <= 1'b0;
            m_g0     <= 1'b0;
            m_g1     <= 1'b0;
            m_rnd    <= 8'h00;
        end else begin
            m_g0 <= 1'b0;
            m_g1 <= 1'b0;
            if (seed_load) begin
                b = ~seed;
                if (b == 8'h00) b = 8'h01;
                m_word     <= shiftn(b, STEPS);
                m_rdy_edge <= ecount + STEPS;
                m_seeded   <= 1'b1;
            end else if (m_seeded && ecount > m_rdy_edge && (req0 || req1)) begin
                who = (req0 && req1) ? m_prio : req1;
                m_g0       <= ~who;
                m_g1       <= who;
                m_prio     <= ~who;
                m_rnd      <= m_word;
                m_word     <= shiftn(m_word, STEPS);
                m_rdy_edge <= ecount + STEPS;
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt0", gnt0, m_g0);
        chk("gnt1", gnt1, m_g1);
        chk("gnt_excl", gnt0 & gnt1, 0);
        chk("rnd", rnd, m_rnd);
        chk("ready", ready, m_seeded && (ecount > m_rdy_edge));
        chk("seeded", seeded, m_seeded);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [7:0] s);
        seed      = s;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            step();
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(gnt0 || gnt1) && n < 40);
        if (!(gnt0 || gnt1)) chk("gnt_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) step();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_rnd", rnd, 0);
        chk("rst_ready", ready, 0);
        chk("rst_seeded", seeded, 0);
        rst_n = 1'b1;

        // Unseeded: requests are ignored.
        req0 = 1'b1;
        repeat (20) step();
        chk("unseeded_ready", ready, 0);
        chk("unseeded_seeded", seeded, 0);
        req0 = 1'b0;

        // Seed 0x00 -> FF, FE, FC, F8, F0; then grants F0 and 01.
        load_seed(8'h00);
        chk("load_notready", ready, 0);
        wait_ready(n);
        chk("ready_lat", n, 4);
        req0 = 1'b1;
        wait_gnt(n);
        chk("g0_lat", n, 1);
        chk("g0_pulse", gnt0, 1);
        chk("g0_rnd", rnd, 8'hF0);
        chk("model_rnd_f0", m_rnd, 8'hF0);
        req0 = 1'b0;
        req1 = 1'b1;
        wait_gnt(n);
        chk("g1_space", n, 5);
        chk("g1_pulse", gnt1, 1);
        chk("g1_rnd", rnd, 8'h01);
        req1 = 1'b0;

        // Round-robin with both requesters held.
        load_seed(8'h5A);
        wait_ready(n);
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(n);
            chk("rr_space", n, (k == 0) ? 1 : 5);
            chk("rr_who", gnt1, k % 2);
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // Seed 0xFF loads 0x01 -> 02, 04, 08, 10.
        load_seed(8'hFF);
        wait_ready(n);
        req0 = 1'b1;
        wait_gnt(n);
        chk("lockup_rnd", rnd, 8'h10);
        req0 = 1'b0;

        // Reload mid-stir with 0x0F: q=F0 and the count restarts.
        load_seed(8'h33);
        step();
        step();
        load_seed(8'h0F);
        wait_ready(n);
        chk("restir_lat", n, 4);
        req1 = 1'b1;
        wait_gnt(n);
        chk("restir_rnd", rnd, 8'h01);
        req1 = 1'b0;

        // Seed load in READY beats a request.
        wait_ready(n);
        req0 = 1'b1;
        seed = 8'h00;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        req0 = 1'b0;
        chk("loadwin_gnt", gnt0 | gnt1, 0);
        chk("loadwin_ready", ready, 0);

        // Reset mid-stir clears outputs at once.
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_rnd", rnd, 0);
        chk("abort_seeded", seeded, 0);
        chk("abort_gnt", gnt0 | gnt1, 0);
        chk("abort_ready", ready, 0);
        #1;
        rst_n = 1'b1;
        req0 = 1'b1;
        repeat (20) step();
        chk("after_abort_ready", ready, 0);
        req0 = 1'b0;

        // Random protocol-following traffic.
        for (int c = 0; c < 4000; c++) begin
            if (gnt0) req0 = 1'b0;
            else if (!req0) req0 = ($urandom_range(0, 3) == 0);
            if (gnt1) req1 = 1'b0;
            else if (!req1) req1 = ($urandom_range(0, 3) == 0);
            seed_load = ($urandom_range(0, 40) == 0);
            seed = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) seed = 8'hFF;
            if ($urandom_range(0, 600) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            step();
        end
        seed_load = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
